// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single memory channel
// Fetch port (r0, read-only) and data port (r1) share one outstanding memory command.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 128,
  parameter int MASK_W  = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              r0_req,
  input  logic [ADDR_W-1:0] r0_addr,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_done,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic [MASK_W-1:0] r1_mask,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic              err,
  output logic [1:0]        m_rw_flag,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic [MASK_W-1:0] m_mask,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_busy,
  input  logic              m_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_gnt;
  logic                r_last;
  logic                r_we;
  logic                r_err;
  logic [CNT_W-1:0]    r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [MASK_W-1:0]   r_mask;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;
  logic                w_any_req;
  logic                w_gnt1;
  logic                w_timeout;
  logic                w_capture;

  // r_last = 1 means r1 was granted last, so r0 wins the next tie
  assign w_any_req = r0_req | r1_req;
  assign w_gnt1    = r1_req & (~r0_req | ~r_last);
  assign w_timeout = (r_state == S_WAIT) && !m_done && (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_capture = m_done && !r_we && ((r_state == S_ISSUE) || (r_state == S_WAIT));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_next = S_ISSUE;
      S_ISSUE: begin
        if (m_done)      w_next = S_RESP;
        else if (m_busy) w_next = S_WAIT;
      end
      S_WAIT:  if (m_done || w_timeout) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_gnt    <= 1'b0;
      r_last   <= 1'b0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_mask   <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      if ((r_state == S_IDLE) && w_any_req) begin
        r_gnt   <= w_gnt1;
        r_last  <= w_gnt1;
        r_we    <= w_gnt1 & r1_we;
        r_addr  <= w_gnt1 ? r1_addr : r0_addr;
        r_wdata <= w_gnt1 ? r1_wdata : '0;
        r_mask  <= w_gnt1 ? r1_mask : '0;
      end
      // Counter restarts whenever we are outside WAIT, so it is zero on entry
      r_cnt <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;
      r_err <= w_timeout;
      if (w_capture) begin
        if (r_gnt) r_rdata1 <= m_rdata;
        else       r_rdata0 <= m_rdata;
      end
    end
  end

  assign m_rw_flag = (r_state == S_ISSUE) ? (r_we ? 2'b10 : 2'b01) : 2'b00;
  assign m_addr    = r_addr;
  assign m_wdata   = r_wdata;
  assign m_mask    = r_mask;
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;
  assign r0_done   = (r_state == S_RESP) && !r_gnt;
  assign r1_done   = (r_state == S_RESP) && r_gnt;
  assign err       = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         r0_req = 1'b0;
  logic [31:0]  r0_addr = '0;
  logic [127:0] r0_rdata;
  logic         r0_done;
  logic         r1_req = 1'b0;
  logic         r1_we = 1'b0;
  logic [31:0]  r1_addr = '0;
  logic [127:0] r1_wdata = '0;
  logic [15:0]  r1_mask = '0;
  logic [127:0] r1_rdata;
  logic         r1_done;
  logic         err;
  logic [1:0]   m_rw_flag;
  logic [31:0]  m_addr;
  logic [127:0] m_wdata;
  logic [15:0]  m_mask;
  logic [127:0] m_rdata = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(128), .MASK_W(16), .TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RST(RST),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_rdata(r0_rdata), .r0_done(r0_done),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_mask(r1_mask), .r1_rdata(r1_rdata), .r1_done(r1_done), .err(err),
    .m_rw_flag(m_rw_flag), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
    .m_rdata(m_rdata), .m_busy(m_busy), .m_done(m_done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  logic [127:0] a5;
  logic [31:0]  exp_addr [4];
  logic         exp_g1   [4];

  initial begin
    a5 = {16{8'hA5}};
    exp_addr = '{32'h2000, 32'h1000, 32'h2000, 32'h1000};
    exp_g1   = '{1'b1, 1'b0, 1'b1, 1'b0};

    // reset state, both requesters already pending
    r0_req = 1'b1; r0_addr = 32'h1000;
    r1_req = 1'b1; r1_addr = 32'h2000;
    tick(); tick();
    chk("rst_flag", m_rw_flag, 2'b00);
    chk("rst_addr", m_addr, 0);
    chk("rst_r0_rdata", r0_rdata, 0);
    chk("rst_r1_rdata", r1_rdata, 0);
    chk("rst_done", {r0_done, r1_done, err}, 3'b000);
    RST = 1'b1;
    tick();

    // tie arbitration with held requests; busy+done together in ISSUE
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rr_addr%0d", g), m_addr, exp_addr[g]);
      chk($sformatf("rr_flag%0d", g), m_rw_flag, 2'b01);
      m_done = 1'b1; m_busy = 1'b1; m_rdata = 128'(g + 1) * 128'h11;
      tick();
      chk($sformatf("rr_done%0d", g), {r1_done, r0_done}, exp_g1[g] ? 2'b10 : 2'b01);
      chk($sformatf("rr_rdata%0d", g), exp_g1[g] ? r1_rdata : r0_rdata, 128'(g + 1) * 128'h11);
      m_done = 1'b0; m_busy = 1'b0;
      if (g == 3) begin r0_req = 1'b0; r1_req = 1'b0; end
      tick();
      chk($sformatf("rr_single%0d", g), {r1_done, r0_done, m_rw_flag}, 4'b0000);
      if (g < 3) tick();
    end

    // fetch read with 3 wait cycles
    r0_req = 1'b1; r0_addr = 32'h100;
    tick();
    chk("rd_flag", m_rw_flag, 2'b01);
    chk("rd_addr", m_addr, 32'h100);
    m_busy = 1'b1;
    tick();
    chk("rd_wait_flag", m_rw_flag, 2'b00);
    chk("rd_wait_addr", m_addr, 32'h100);
    tick(); tick();
    m_done = 1'b1; m_rdata = a5;
    tick();
    chk("rd_done", {r0_done, r1_done, err}, 3'b100);
    chk("rd_rdata", r0_rdata, a5);
    r0_req = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    tick();
    chk("rd_done_clr", r0_done, 1'b0);

    // data write; request fields change after grant
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h300; r1_wdata = 128'h1234; r1_mask = 16'h000F;
    tick();
    chk("wr_flag", m_rw_flag, 2'b10);
    chk("wr_mask", m_mask, 16'h000F);
    chk("wr_wdata", m_wdata, 128'h1234);
    r1_we = 1'b0; r1_addr = 32'hDEAD; r1_mask = 16'hFFFF; r1_wdata = 128'h9999;
    m_busy = 1'b1;
    tick();
    chk("wr_hold", {m_rw_flag, m_addr, m_mask}, {2'b00, 32'h300, 16'h000F});
    m_done = 1'b1; m_rdata = 128'hBAD;
    tick();
    chk("wr_done", r1_done, 1'b1);
    chk("wr_rdata_keep", r1_rdata, 128'h33);
    r1_req = 1'b0; m_done = 1'b0; m_busy = 1'b0;
    tick();

    // timeout after 8 WAIT cycles
    r1_req = 1'b1; r1_addr = 32'h400;
    tick();
    m_busy = 1'b1; m_rdata = 128'h77;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("to_wait%0d", i), {r1_done, err}, 2'b00);
      tick();
    end
    chk("to_resp", {r1_done, err}, 2'b11);
    chk("to_rdata_keep", r1_rdata, 128'h33);
    r1_req = 1'b0; m_busy = 1'b0;
    tick();
    chk("to_idle", {r1_done, err, m_rw_flag}, 4'b0000);

    // reset during WAIT, then fresh arbitration
    r1_req = 1'b1; r1_addr = 32'h500;
    tick();
    m_busy = 1'b1;
    tick();
    chk("ab_wait_addr", m_addr, 32'h500);
    RST = 1'b0;
    #1;
    chk("ab_outs", {m_rw_flag, m_addr, m_mask, r0_done, r1_done, err}, 0);
    chk("ab_rdata", {r0_rdata, r1_rdata}, 0);
    r1_req = 1'b0; m_busy = 1'b0;
    tick();
    RST = 1'b1;
    tick();
    chk("ab_nodone1", {r0_done, r1_done}, 2'b00);
    tick();
    chk("ab_nodone2", {r0_done, r1_done, m_rw_flag}, 4'b0000);
    r0_req = 1'b1; r0_addr = 32'h600; r1_req = 1'b1; r1_addr = 32'h700;
    tick();
    chk("ab_fresh_addr", m_addr, 32'h700);
    chk("ab_fresh_flag", m_rw_flag, 2'b01);
    m_done = 1'b1; m_rdata = 128'h66;
    tick();
    chk("ab_fresh_done", {r1_done, r0_done}, 2'b10);
    chk("ab_fresh_rdata", r1_rdata, 128'h66);
    r0_req = 1'b0; r1_req = 1'b0; m_done = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 128, data width.
REQ-003 SHALL have parameter MASK_W, default 16, byte-mask width.
REQ-004 SHALL have parameter TIMEOUT, default 1023, the maximum number of WAIT cycles before abort.
REQ-005 SHALL have port CLK, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port RST, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port r0_req, input, 1 bit, instruction-fetch read request, held until r0_done.
REQ-008 SHALL have port r0_addr, input, ADDR_W bits, fetch address.
REQ-009 SHALL have port r0_rdata, output, DATA_W bits, fetch read data, registered.
REQ-010 SHALL have port r0_done, output, 1 bit, one-cycle completion pulse for requester 0.
REQ-011 SHALL have port r1_req, input, 1 bit, data-access request, held until r1_done.
REQ-012 SHALL have port r1_we, input, 1 bit; 1 = write, 0 = read.
REQ-013 SHALL have port r1_addr, input, ADDR_W bits, data address.
REQ-014 SHALL have port r1_wdata, input, DATA_W bits, write data.
REQ-015 SHALL have port r1_mask, input, MASK_W bits, byte write mask.
REQ-016 SHALL have port r1_rdata, output, DATA_W bits, data read result, registered.
REQ-017 SHALL have port r1_done, output, 1 bit, one-cycle completion pulse for requester 1.
REQ-018 SHALL have port err, output, 1 bit, one-cycle timeout pulse, accompanies the done pulse of the aborted requester.
REQ-019 SHALL have port m_rw_flag, output, 2 bits, memory-channel command: 00 idle, 01 read, 10 write.
REQ-020 SHALL have port m_addr, output, ADDR_W bits; m_wdata, output, DATA_W bits; m_mask, output, MASK_W bits; latched command fields.
REQ-021 SHALL have port m_rdata, input, DATA_W bits; m_busy, input, 1 bit; m_done, input, 1 bit; the memory-channel response.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-023 IDLE: when any req is high, SHALL grant one requester, latch its addr/wdata/mask/we into internal registers, record the grant, and enter ISSUE.
REQ-024 Arbitration: a single requester SHALL be granted; when both request, the requester not granted last SHALL win; after reset the last-grant pointer SHALL be 0, so r1 wins the first tie.
REQ-025 Requester 0 SHALL always issue reads; r1_we=1 SHALL issue 10, otherwise 01.
REQ-026 ISSUE: m_rw_flag SHALL be driven from latched fields; on m_busy=1, next state WAIT.
REQ-027 ISSUE with m_done=1 in the same cycle SHALL be treated as completion and go directly to RESP.
REQ-028 WAIT: m_rw_flag SHALL be 00 and m_addr/m_wdata/m_mask SHALL hold latched values; on m_done=1, SHALL capture m_rdata for a read, then go to RESP.
REQ-029 WAIT cycle counter: SHALL clear on entry; on reaching TIMEOUT without m_done, SHALL set err for the RESP cycle, leave rdata unchanged, and go to RESP.
REQ-030 RESP: SHALL last exactly one cycle with the granted requester's done=1 and no arbitration, then go to IDLE.
REQ-031 Requesters SHALL deassert req at the edge ending their done cycle; req high in IDLE after RESP SHALL be a new request.
REQ-032 Latency: req sampled in IDLE at edge N SHALL give m_rw_flag valid in cycle N+1; done SHALL be high one cycle after the edge sampling m_done.
REQ-033 Changes on req or request fields after grant SHALL be ignored; the latched transaction SHALL complete and done SHALL still pulse.
REQ-034 At most one transaction SHALL be outstanding; a non-granted req SHALL wait with no loss.

Reset
REQ-035 On RST=0, asynchronously: state IDLE, m_rw_flag=00, m_addr/m_wdata/m_mask=0, r0_rdata=r1_rdata=0, r0_done=r1_done=err=0, last-grant=0, counter=0.
REQ-036 Reset mid-transaction SHALL abort with no done pulse; the first request after release SHALL be arbitrated fresh.

Verification
REQ-037 r0_req, addr 0x100; busy next cycle, done 3 cycles later with m_rdata=0xA5.. -> flag 01 for one cycle, r0_rdata=0xA5.., r0_done one pulse.
REQ-038 r0_req and r1_req both high from reset, held -> grant order r1, r0, r1, r0 on m_addr.
REQ-039 r1 write, mask 0x000F, wdata 0x1234 -> flag 10, m_mask=0x000F, r1_rdata unchanged, r1_done pulse.
REQ-040 ISSUE with m_busy and m_done both high same cycle -> RESP next cycle, single done, no WAIT.
REQ-041 TIMEOUT=8, m_done never asserted -> err and r1_done together 8 WAIT cycles after entry, FSM back to IDLE.
REQ-042 RST low during WAIT -> all outputs 0 at once; no done after release; the next request is served normally.
